// File: rtl/match_event_logger.sv
// match_event_logger
// Watches the pattern detector's two match outputs (y_in from the FSM,
// e_in from the shift-register compare). Every rising edge of y_in is
// counted, timestamped and queued in a small FIFO that is read through a
// valid/ready port. Any cycle where the two detector outputs disagree is
// counted and latched into a sticky error flag.
module match_event_logger #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             e_in,
  input  logic             rd_ready,
  output logic             ts_valid,
  output logic [TS_W:0]    ts_data,
  output logic             fifo_full,
  output logic             overflow,
  output logic             agree_err,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

  // Input stage and free-running timestamp
  logic            y_q;
  logic            y_qq;
  logic            e_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_cnt;

  // FIFO state
  logic [TS_W:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  // Handshake and event decode
  logic evt;
  logic pop;
  logic push;
  logic drop;

  // A level held high for several cycles produces one event on its first
  // registered cycle. Because y_qq resets to 0, a y_in that is already high
  // right after reset also counts.
  assign evt  = y_q & ~y_qq;
  assign pop  = ts_valid & rd_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = evt & (~fifo_full | pop);
  assign drop = evt & fifo_full & ~pop;

  // Status and head presentation derive only from stored state, so nothing
  // here depends combinationally on rd_ready.
  assign ts_valid  = (occ != '0);
  assign fifo_full = (occ == OCC_FULL);
  assign ts_data   = mem[rd_ptr];

  // Register the detector outputs and the timestamp counter
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= 1'b0;
      y_qq   <= 1'b0;
      e_q    <= 1'b0;
      ts_q   <= '0;
      ts_cnt <= '0;
    end else begin
      y_q    <= y_in;
      y_qq   <= y_q;
      e_q    <= e_in;
      ts_q   <= ts_cnt;
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Entry storage; contents are only observed while occupied, so the
  // array is not cleared on reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {e_q, ts_q};
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky flags and saturating event / disagreement counters
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow       <= 1'b0;
      agree_err      <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      // Dropped events are still counted as matches.
      if (evt && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
      if (y_q != e_q) begin
        agree_err <= 1'b1;
        if (mismatch_count != '1) begin
          mismatch_count <= mismatch_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Testbench for match_event_logger. Two instances share the stimulus:
// one with default widths, one with TS_W=4 / CNT_W=2 for wrap and
// saturation. A queue-based reference model tracks the expected FIFO,
// flags and unsaturated counts; each instance is compared after masking.
module tb_match_event_logger;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic y_in = 1'b0;
  logic e_in = 1'b0;
  logic rd_ready = 1'b0;

  logic        ts_valid_a, fifo_full_a, overflow_a, agree_err_a;
  logic [16:0] ts_data_a;
  logic [7:0]  match_count_a, mismatch_count_a;

  logic        ts_valid_b, fifo_full_b, overflow_b, agree_err_b;
  logic [4:0]  ts_data_b;
  logic [1:0]  match_count_b, mismatch_count_b;

  match_event_logger #(.TS_W(16), .CNT_W(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .y_in(y_in), .e_in(e_in), .rd_ready(rd_ready),
    .ts_valid(ts_valid_a), .ts_data(ts_data_a), .fifo_full(fifo_full_a),
    .overflow(overflow_a), .agree_err(agree_err_a),
    .match_count(match_count_a), .mismatch_count(mismatch_count_a)
  );

  match_event_logger #(.TS_W(4), .CNT_W(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .y_in(y_in), .e_in(e_in), .rd_ready(rd_ready),
    .ts_valid(ts_valid_b), .ts_data(ts_data_b), .fifo_full(fifo_full_b),
    .overflow(overflow_b), .agree_err(agree_err_b),
    .match_count(match_count_b), .mismatch_count(mismatch_count_b)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct { bit e; int ts; } ent_t;
  ent_t q[$];
  int   k;          // current cycle number since reset release
  int   mcnt;       // events seen, unsaturated
  int   mmcnt;      // disagreement cycles, unsaturated
  bit   ovf;
  bit   aerr;
  bit   seen_y, seen_e, older_y;  // inputs of the previous two cycles
  int   seen_ts;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference: an input edge seen in the previous
  // cycle becomes an event now; head leaves first when a handshake happens.
  task automatic model_edge();
    bit pop, evt, mism, was_full;
    if (rst) begin
      q.delete();
      k = 0; mcnt = 0; mmcnt = 0; ovf = 0; aerr = 0;
      seen_y = 0; seen_e = 0; older_y = 0; seen_ts = 0;
    end else begin
      pop      = (q.size() != 0) && rd_ready;
      evt      = seen_y && !older_y;
      mism     = (seen_y != seen_e);
      was_full = (q.size() == 4);
      if (pop) void'(q.pop_front());
      if (evt) begin
        mcnt++;
        if (was_full && !pop) ovf = 1;
        else q.push_back('{seen_e, seen_ts});
      end
      if (mism) begin
        mmcnt++;
        aerr = 1;
      end
      older_y = seen_y;
      seen_y  = y_in;
      seen_e  = e_in;
      seen_ts = k;
      k++;
    end
  endtask

  task automatic compare_all();
    check("a_valid", ts_valid_a, q.size() != 0);
    check("a_full", fifo_full_a, q.size() == 4);
    if (q.size() != 0) check("a_data", ts_data_a, {q[0].e, q[0].ts[15:0]});
    check("a_ovf", overflow_a, ovf);
    check("a_aerr", agree_err_a, aerr);
    check("a_mcnt", match_count_a, sat(mcnt, 255));
    check("a_mmcnt", mismatch_count_a, sat(mmcnt, 255));
    check("b_valid", ts_valid_b, q.size() != 0);
    check("b_full", fifo_full_b, q.size() == 4);
    if (q.size() != 0) check("b_data", ts_data_b, {q[0].e, q[0].ts[3:0]});
    check("b_ovf", overflow_b, ovf);
    check("b_aerr", agree_err_b, aerr);
    check("b_mcnt", match_count_b, sat(mcnt, 3));
    check("b_mmcnt", mismatch_count_b, sat(mmcnt, 3));
  endtask

  // Apply inputs for the current cycle, clock, then check one cycle later
  task automatic step(bit y, bit e, bit r);
    y_in = y; e_in = e; rd_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_to(int target, bit r);
    while (k < target) step(1'b0, 1'b0, r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  logic [16:0] exp_a;
  logic [4:0]  exp_b;
  int          wrap_ts [5] = '{3, 10, 1, 8, 15};
  bit          yv, ev, rv;

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", ts_valid_a, 1'b0);
    check("rst_full", fifo_full_a, 1'b0);
    check("rst_mcnt", match_count_a, 8'd0);

    // Single match at cycle 5
    run_to(5, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("single_latency", ts_valid_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("single_valid", ts_valid_a, 1'b1);
    check("single_data", ts_data_a, {1'b1, 16'd5});
    check("single_mcnt", match_count_a, 8'd1);
    check("single_aerr", agree_err_a, 1'b0);

    // Disagreement at cycle 10
    run_to(10, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("dis_aerr_early", agree_err_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("dis_aerr", agree_err_a, 1'b1);
    check("dis_mmcnt", mismatch_count_a, 8'd1);
    step(1'b0, 1'b0, 1'b1);
    check("dis_data", ts_data_a, {1'b0, 16'd10});
    step(1'b0, 1'b0, 1'b1);
    check("dis_empty", ts_valid_a, 1'b0);

    // Overflow: five pulses into a four-entry FIFO
    do_reset();
    for (int p = 2; p <= 10; p += 2) begin
      run_to(p, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check("ovf_early", overflow_a, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("ovf_full", fifo_full_a, 1'b1);
    check("ovf_flag", overflow_a, 1'b1);
    check("ovf_mcnt", match_count_a, 8'd5);
    for (int i = 0; i < 4; i++) begin
      exp_a = {1'b1, 16'(2 + 2 * i)};
      check("ovf_drain", ts_data_a, exp_a);
      step(1'b0, 1'b0, 1'b1);
    end
    check("ovf_drained", ts_valid_a, 1'b0);

    // Full FIFO with push and pop on the same edge
    do_reset();
    for (int p = 2; p <= 10; p += 2) begin
      run_to(p, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check("pp_full", fifo_full_a, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("pp_still_full", fifo_full_a, 1'b1);
    check("pp_no_ovf", overflow_a, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_a = {1'b1, 16'(4 + 2 * i)};
      check("pp_drain", ts_data_a, exp_a);
      step(1'b0, 1'b0, 1'b1);
    end
    check("pp_drained", ts_valid_a, 1'b0);

    // Timestamp wrap and count saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_to(3 + 7 * i, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      exp_b = {1'b1, 4'(wrap_ts[i])};
      check("wrap_valid", ts_valid_b, 1'b1);
      check("wrap_data", ts_data_b, exp_b);
    end
    check("sat_mcnt_b", match_count_b, 2'd3);
    check("sat_mcnt_a", match_count_a, 8'd5);

    // Reset with entries queued and rd_ready high during reset
    do_reset();
    run_to(2, 1'b0); step(1'b1, 1'b1, 1'b0);
    run_to(4, 1'b0); step(1'b1, 1'b1, 1'b0);
    run_to(6, 1'b0); step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mid_aerr_set", agree_err_a, 1'b1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("mid_valid", ts_valid_a, 1'b0);
    check("mid_mcnt", match_count_a, 8'd0);
    check("mid_mmcnt", mismatch_count_a, 8'd0);
    check("mid_aerr", agree_err_a, 1'b0);
    check("mid_ovf", overflow_a, 1'b0);
    run_to(2, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("mid_new_data", ts_data_a, {1'b1, 16'd2});

    // Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
      end else begin
        yv = 1'($urandom_range(0, 1));
        ev = ($urandom_range(0, 4) == 0) ? ~yv : yv;
        rv = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        step(yv, ev, rv);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial pattern detector's outputs. Samples the FSM match pulse `y_in` and the shift-register compare flag `e_in` every cycle. For each new match it counts the event, timestamps it and queues it in a small FIFO behind a valid/ready read port. It also cross-checks the two detector outputs cycle by cycle and reports any disagreement.

## Interface
Parameters:
- `TS_W`, default 16: timestamp counter width.
- `CNT_W`, default 8: width of `match_count` and `mismatch_count`.
- `DEPTH`, default 4: FIFO entries; power of 2, minimum 2.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `y_in`  in  1: detector FSM match output.
- `e_in`  in  1: detector shift-register compare output.
- `rd_ready`  in  1: consumer accepts the head entry.
- `ts_valid`  out  1: FIFO non-empty, head entry presented.
- `ts_data`  out  TS_W+1: `{e_at_match, timestamp}`; MSB is the `e_in` value sampled together with the `y_in` rising edge.
- `fifo_full`  out  1: occupancy == DEPTH.
- `overflow`  out  1: sticky; an event was dropped.
- `agree_err`  out  1: sticky; `y_in` != `e_in` was seen.
- `match_count`  out  CNT_W: `y_in` rising edges, saturating.
- `mismatch_count`  out  CNT_W: cycles with `y_in` != `e_in`, saturating.

## Operation
- **Input stage.** `y_q`, `e_q`, `ts_q` register `y_in`, `e_in`, `ts_cnt` every cycle. `y_qq` registers `y_q`.
- **Timestamp counter.** `ts_cnt` is 0 in the first cycle after `rst` is sampled low. It increments every cycle and wraps 2^TS_W-1 -> 0 with no flag.
- **Event detection.**
  - `event = y_q & ~y_qq`.
  - A `y_in` level held for N cycles is one event.
  - A `y_in` that is high in the first cycle after reset counts as an event.
- **Counters.**
  - On `event`, `match_count` increments, saturating at 2^CNT_W-1. It counts every event, including dropped ones.
  - When `y_q != e_q`, `mismatch_count` increments, saturating at 2^CNT_W-1, and `agree_err` sets.
- **FIFO.**
  - Circular buffer with read pointer, write pointer and an occupancy counter of width log2(DEPTH)+1.
  - Push occurs when `event & (!fifo_full | pop)`. Pushed data is `{e_q, ts_q}`.
  - Pop occurs when `ts_valid & rd_ready`.
  - Push and pop in the same cycle:
    - Occupancy is unchanged.
    - When full, the push is accepted because a slot frees the same edge.
    - When empty, only the push takes effect, since no pop is possible.
  - `event` with `fifo_full & !pop` drops the event and sets `overflow`. The FIFO contents are untouched.
  - Pointers wrap modulo DEPTH.
  - `ts_data` equals the head entry whenever `ts_valid` = 1. It is don't-care otherwise.
  - `ts_data` and `ts_valid` must not depend combinationally on `rd_ready`.
- **Reset.**
  - Values on the edge where `rst` = 1: all registers, pointers and occupancy go to 0; `ts_valid`, `fifo_full`, `overflow` and `agree_err` go to 0; both counters go to 0.
  - Reset mid-operation discards queued entries. Nothing is popped during reset.
  - `rd_ready` is ignored while `rst` = 1.

## Timing
- Event latency, `y_in` rising edge to head of an empty FIFO:
  - `y_in` rises in cycle t, with `ts_cnt` = t.
  - `y_q` is high in cycle t+1 and the push happens at the end of t+1.
  - `ts_valid` = 1 in cycle t+2 with `ts_data[TS_W-1:0]` = t.
- Mismatch latency: `y_in` != `e_in` in cycle t gives `agree_err` = 1 and a `mismatch_count` increment visible in cycle t+2.
- `match_count` is visible in cycle t+2 for a rising edge in cycle t.
- Pop: a handshake in cycle c removes the head. The next entry, or `ts_valid` = 0, shows in cycle c+1.
- Throughput: one push and one pop per cycle. Minimum event spacing is 2 cycles, set by edge detection.

## Test plan
- **Single match.** Reset, then `y_in` = `e_in` = 1 in cycle 5 only, `rd_ready` = 0 -> in cycle 7: `ts_valid` = 1, `ts_data` = {1, 16'd5}, `match_count` = 1, `mismatch_count` = 0, `agree_err` = 0.
- **Disagreement.** `y_in` = 1, `e_in` = 0 in cycle 10 -> `ts_data` = {0, 16'd10}; `agree_err` = 1 and `mismatch_count` = 1 from cycle 12.
- **Overflow.** DEPTH=4, `rd_ready` = 0, pulses at cycles 2, 4, 6, 8, 10 -> `fifo_full` = 1 from cycle 10, `overflow` = 1 from cycle 12, `match_count` = 5. Draining yields timestamps 2, 4, 6, 8, then `ts_valid` = 0.
- **Full with simultaneous push/pop.** FIFO full, `rd_ready` = 1 in the same cycle as the next push -> occupancy stays 4, `overflow` stays 0, the new timestamp becomes the tail.
- **Wrap and saturation.** TS_W=4, CNT_W=2, 5 pulses spaced 7 cycles from cycle 3 (3, 10, 17, 24, 31) -> timestamps 3, 10, 1, 8, 15; `match_count` saturates at 3.
- **Reset mid-operation.** 3 entries queued, `rst` pulsed 1 cycle -> next cycle `ts_valid` = 0, all counters 0, all flags 0. A new pulse 2 cycles after reset release reads timestamp 2.
